csr_trap: RTL

Machine-mode CSR file and trap controller. It produces the trap-side inputs of the next-address generator: mtvec, mepc, mcause, the trap-taken strobe and the mret strobe. It executes CSR read/modify/write instructions and performs trap entry and return bookkeeping. It arbitrates synchronous exceptions against pending interrupts.

---
 rtl/csr_trap.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/csr_trap.sv
// Machine-mode CSR file and trap controller.
// Executes CSR read/modify/write accesses, arbitrates synchronous exceptions
// against pending interrupts, and performs trap entry / mret bookkeeping.
module csr_trap #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_pause,
    input  logic            i_csr_en,
    input  logic [1:0]      i_csr_op,
    input  logic [11:0]     i_csr_addr,
    input  logic [XLEN-1:0] i_csr_wdata,
    output logic [XLEN-1:0] o_csr_rdata,
    output logic            o_csr_illegal,
    input  logic            i_exc_valid,
    input  logic [3:0]      i_exc_code,
    input  logic [XLEN-1:0] i_exc_pc,
    input  logic [XLEN-1:0] i_exc_tval,
    input  logic [XLEN-1:0] i_int_pc,
    input  logic            i_mret,
    input  logic            i_irq_sw,
    input  logic            i_irq_timer,
    input  logic            i_irq_ext,
    output logic            o_s_exception,
    output logic            o_s_mret,
    output logic [XLEN-1:0] o_mtvec,
    output logic [XLEN-1:0] o_mepc,
    output logic [XLEN-1:0] o_mcause
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;

    localparam logic [XLEN-1:0] MIE_BIT      = XLEN'(32'h0000_0008);
    localparam logic [XLEN-1:0] MPIE_BIT     = XLEN'(32'h0000_0080);
    localparam logic [XLEN-1:0] MSTATUS_MASK = XLEN'(32'h0000_0088);
    localparam logic [XLEN-1:0] MPP_BITS     = XLEN'(32'h0000_1800);
    localparam logic [XLEN-1:0] IRQ_MASK     = XLEN'(32'h0000_0888);
    localparam logic [XLEN-1:0] ALIGN_MASK   = ~XLEN'(32'h0000_0003);

    // Architectural state; only the writable bits of masked CSRs are ever set.
    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] r_mie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic [2:0]      r_mip;      // {ext, timer, sw}
    logic [XLEN-1:0] r_mcycle;

    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_mip;
    logic [XLEN-1:0] w_old;
    logic            w_impl;
    logic [XLEN-1:0] w_new;
    logic            w_write_req;
    logic            w_wr_commit;
    logic [XLEN-1:0] w_pend_vec;
    logic            w_int_pend;
    logic [3:0]      w_int_code;
    logic            w_trap;
    logic            w_mret_take;
    logic [XLEN-1:0] w_cause_new;

    assign w_mstatus = r_mstatus | MPP_BITS;
    assign w_mip     = {{(XLEN-12){1'b0}}, r_mip[2], 3'b000, r_mip[1], 3'b000, r_mip[0], 3'b000};

    // Decode the addressed CSR and its current value.
    always_comb begin
        w_impl = 1'b1;
        w_old  = '0;
        case (i_csr_addr)
            ADDR_MSTATUS:  w_old = w_mstatus;
            ADDR_MIE:      w_old = r_mie;
            ADDR_MTVEC:    w_old = r_mtvec;
            ADDR_MSCRATCH: w_old = r_mscratch;
            ADDR_MEPC:     w_old = r_mepc;
            ADDR_MCAUSE:   w_old = r_mcause;
            ADDR_MTVAL:    w_old = r_mtval;
            ADDR_MIP:      w_old = w_mip;
            ADDR_MCYCLE:   w_old = r_mcycle;
            default:       w_impl = 1'b0;
        endcase
    end

    // Read/modify/write operand for the access.
    always_comb begin
        w_new = w_old;
        case (i_csr_op)
            2'b01:   w_new = i_csr_wdata;
            2'b10:   w_new = w_old | i_csr_wdata;
            2'b11:   w_new = w_old & ~i_csr_wdata;
            default: w_new = w_old;
        endcase
    end

    assign o_csr_rdata   = (i_csr_en && w_impl) ? w_old : '0;
    assign w_write_req   = i_csr_en && (i_csr_op != 2'b00);
    assign o_csr_illegal = i_reset && i_csr_en &&
                           (!w_impl || ((i_csr_op != 2'b00) && (i_csr_addr[11:10] == 2'b11)));

    // Interrupt arbitration: ext > sw > timer.
    assign w_pend_vec = r_mie & w_mip;
    assign w_int_pend = r_mstatus[3] && (|w_pend_vec);
    always_comb begin
        if (w_pend_vec[11]) begin
            w_int_code = 4'd11;
        end else if (w_pend_vec[3]) begin
            w_int_code = 4'd3;
        end else begin
            w_int_code = 4'd7;
        end
    end

    assign w_trap      = i_reset && !i_pause && (i_exc_valid || w_int_pend);
    assign w_mret_take = i_reset && i_mret && !i_pause && !w_trap;
    assign w_wr_commit = i_reset && w_write_req && !o_csr_illegal && !i_pause && !w_trap;
    assign w_cause_new = i_exc_valid ? {{(XLEN-4){1'b0}}, i_exc_code}
                                     : {1'b1, {(XLEN-5){1'b0}}, w_int_code};

    assign o_s_exception = w_trap;
    assign o_s_mret      = w_mret_take;
    assign o_mtvec       = r_mtvec;
    assign o_mepc        = r_mepc;
    // Bypass so vectored target computation sees the cause of the trap being taken.
    assign o_mcause      = w_trap ? w_cause_new : r_mcause;

    // CSR state: trap beats mret beats CSR write; mstatus write lands after mret.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_mstatus  <= '0;
            r_mie      <= '0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
            r_mip      <= '0;
            r_mcycle   <= '0;
        end else begin
            r_mip <= {i_irq_ext, i_irq_timer, i_irq_sw};

            if (w_wr_commit && (i_csr_addr == ADDR_MCYCLE)) begin
                r_mcycle <= w_new;
            end else begin
                r_mcycle <= r_mcycle + XLEN'(1);
            end

            if (w_trap) begin
                r_mepc    <= (i_exc_valid ? i_exc_pc : i_int_pc) & ALIGN_MASK;
                r_mcause  <= w_cause_new;
                r_mtval   <= i_exc_valid ? i_exc_tval : '0;
                r_mstatus <= r_mstatus[3] ? MPIE_BIT : '0;
            end else begin
                if (w_mret_take) begin
                    r_mstatus <= MPIE_BIT | (r_mstatus[7] ? MIE_BIT : '0);
                end
                if (w_wr_commit) begin
                    case (i_csr_addr)
                        ADDR_MSTATUS:  r_mstatus  <= w_new & MSTATUS_MASK;
                        ADDR_MIE:      r_mie      <= w_new & IRQ_MASK;
                        // Reserved modes (1x) keep the existing mode bits.
                        ADDR_MTVEC:    r_mtvec    <= w_new[1] ? {w_new[XLEN-1:2], r_mtvec[1:0]}
                                                              : w_new;
                        ADDR_MSCRATCH: r_mscratch <= w_new;
                        ADDR_MEPC:     r_mepc     <= w_new & ALIGN_MASK;
                        ADDR_MCAUSE:   r_mcause   <= w_new;
                        ADDR_MTVAL:    r_mtval    <= w_new;
                        default:       ;
                    endcase
                end
            end
        end
    end

endmodule
